// File: rtl/ifu_prefetch_if.sv
// ----------------------------------------------------------------------------
// ifu_prefetch_if
// Bundles the signals around the instruction prefetch buffer:
//   - memory side : mem_req/mem_addr out, mem_gnt/mem_rvalid/mem_rdata in
//   - redirect    : redirect_valid/redirect_pc in (execute or trap unit)
//   - decode side : dec_valid/dec_instr/dec_pc out, dec_ready in
//   - status      : fifo_count out (occupied FIFO entries)
// modport master : the prefetch buffer itself
// modport slave  : the surrounding memory / redirect source / decoder
// ----------------------------------------------------------------------------
interface ifu_prefetch_if #(
  parameter int XLEN    = 32,
  parameter int FETCH_W = 4,
  parameter int DEPTH   = 16
);
  logic                         mem_req;
  logic [XLEN-1:0]              mem_addr;
  logic                         mem_gnt;
  logic                         mem_rvalid;
  logic [FETCH_W*XLEN-1:0]      mem_rdata;
  logic                         redirect_valid;
  logic [XLEN-1:0]              redirect_pc;
  logic                         dec_valid;
  logic                         dec_ready;
  logic [XLEN-1:0]              dec_instr;
  logic [XLEN-1:0]              dec_pc;
  logic [$clog2(DEPTH+1)-1:0]   fifo_count;

  modport master (
    output mem_req, mem_addr, dec_valid, dec_instr, dec_pc, fifo_count,
    input  mem_gnt, mem_rvalid, mem_rdata, redirect_valid, redirect_pc, dec_ready
  );

  modport slave (
    input  mem_req, mem_addr, dec_valid, dec_instr, dec_pc, fifo_count,
    output mem_gnt, mem_rvalid, mem_rdata, redirect_valid, redirect_pc, dec_ready
  );
endinterface

// File: rtl/ifu_prefetch_buffer.sv
// ----------------------------------------------------------------------------
// ifu_prefetch_buffer
// Fetches aligned blocks of FETCH_W instructions from instruction memory into
// a DEPTH-entry FIFO and hands them to decode one per cycle (valid/ready).
// Misaligned fetch targets drop the leading slots of the first block. A new
// request is only issued when a whole block fits (credit check), and only one
// request is ever outstanding. A redirect flushes the FIFO; a response that
// is still in flight at that point is swallowed in DRAIN.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ifu_prefetch_if.master (memory, redirect, decode, fifo_count)
// ----------------------------------------------------------------------------
module ifu_prefetch_buffer #(
  parameter int              XLEN    = 32,
  parameter int              FETCH_W = 4,
  parameter int              DEPTH   = 16,
  parameter logic [XLEN-1:0] RST_PC  = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  ifu_prefetch_if.master bus
);
  localparam int B       = FETCH_W * 4;
  localparam int BLK_LSB = $clog2(B);
  localparam int OFF_W   = BLK_LSB - 2;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic             mem_req_q, mem_req_d;
  logic [XLEN-1:0]  mem_addr_q, mem_addr_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [XLEN-1:0]  instr_q [DEPTH];
  logic [XLEN-1:0]  pc_q    [DEPTH];

  logic [OFF_W-1:0] off;
  logic [XLEN-1:0]  blk;
  logic [CNT_W-1:0] free;
  logic [CNT_W-1:0] n_wr;
  logic             redirect;
  logic             pop;
  logic             beat_wr;

  assign redirect = bus.redirect_valid;
  assign off      = fetch_pc_q[BLK_LSB-1:2];
  assign blk      = {fetch_pc_q[XLEN-1:BLK_LSB], {BLK_LSB{1'b0}}};
  assign free     = CNT_W'(DEPTH) - count_q;

  // A redirect voids both the read handshake and any write of this cycle.
  assign pop      = (count_q != '0) && bus.dec_ready && !redirect;
  assign beat_wr  = (state_q == WAIT) && bus.mem_rvalid && !redirect;
  assign n_wr     = beat_wr ? (CNT_W'(FETCH_W) - CNT_W'(off)) : '0;
  assign count_d  = redirect ? '0 : (count_q + n_wr - CNT_W'(pop));

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      IDLE: begin
        if (!redirect && (free >= CNT_W'(FETCH_W))) begin
          state_d    = REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = blk;
        end
      end
      REQ: begin
        // A grant coinciding with a redirect still owes us a beat: drain it.
        if (bus.mem_gnt) begin
          state_d   = redirect ? DRAIN : WAIT;
          mem_req_d = 1'b0;
        end else if (redirect) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          state_d = IDLE;
          if (!redirect) fetch_pc_d = blk + XLEN'(B);
        end else if (redirect) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The single outstanding beat ends the drain even if another
        // redirect arrives alongside it; nothing else can still be owed.
        if (bus.mem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (redirect) fetch_pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RST_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      count_q    <= count_d;
      if (redirect) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(n_wr);
        if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Burst write: slot i of the block lands at wr_ptr + (i - off); the
  // pointer arithmetic wraps modulo DEPTH so a burst may straddle the end.
  always_ff @(posedge clk) begin
    if (beat_wr) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (i >= int'(off)) begin
          instr_q[wr_ptr_q + PTR_W'(i) - PTR_W'(off)] <= bus.mem_rdata[i*XLEN +: XLEN];
          pc_q[wr_ptr_q + PTR_W'(i) - PTR_W'(off)]    <= blk + XLEN'(4 * i);
        end
      end
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.dec_valid  = (count_q != '0);
  assign bus.dec_instr  = instr_q[rd_ptr_q];
  assign bus.dec_pc     = pc_q[rd_ptr_q];
  assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_ifu_prefetch_buffer.sv
// ----------------------------------------------------------------------------
// tb_ifu_prefetch_buffer
// Drives ifu_prefetch_buffer with a behavioural instruction memory and decoder.
// Reference model: after every redirect to P the decoder must see the
// sequential stream P, P+4, P+8 ... (mod 2^32) with instr = f(pc), block
// requests must walk blk(P), blk(P)+16, ..., and fifo_count equals the
// instructions delivered by non-discarded beats minus those consumed.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ifu_prefetch_buffer;
  localparam int XLEN    = 32;
  localparam int FETCH_W = 4;
  localparam int DEPTH   = 16;
  localparam int B       = FETCH_W * 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifu_prefetch_if #(.XLEN(XLEN), .FETCH_W(FETCH_W), .DEPTH(DEPTH)) bus ();

  ifu_prefetch_buffer #(
    .XLEN(XLEN), .FETCH_W(FETCH_W), .DEPTH(DEPTH), .RST_PC(32'h0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_pc, exp_req, nq, pend_addr;
  int          mcount, lat, lat_min, lat_max;
  bit          pend, pend_stale;
  int          rdy_mode, gnt_mode;  // 0 never, 1 always, 2 random

  function automatic logic [31:0] f(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_pc = 32'h0; nq = 32'h0; exp_req = 32'h0;
    mcount = 0; pend = 1'b0; pend_stale = 1'b0; lat = 0;
  endtask

  // One clock cycle: choose inputs, check outputs, advance the model.
  task automatic cycle(input bit redir, input logic [31:0] rpc);
    bit rv, gnt, rdy, pop;
    rv  = pend && (lat == 0);
    gnt = bus.mem_req && ((gnt_mode == 1) || ((gnt_mode == 2) && ($urandom_range(0, 1) == 1)));
    rdy = (rdy_mode == 1) || ((rdy_mode == 2) && ($urandom_range(0, 2) != 0));
    bus.mem_gnt        = gnt;
    bus.mem_rvalid     = rv;
    bus.dec_ready      = rdy;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    for (int i = 0; i < FETCH_W; i++)
      bus.mem_rdata[i*XLEN +: XLEN] = rv ? f(pend_addr + 32'(4 * i)) : $urandom;

    chk("fifo_count", 32'(bus.fifo_count), 32'(mcount));
    chk("dec_valid", 32'(bus.dec_valid), 32'(mcount != 0));
    chk("one_outstanding", 32'(bus.mem_req && pend), 32'h0);
    if (gnt && !redir) begin
      chk("mem_addr", bus.mem_addr, exp_req);
      exp_req = exp_req + 32'(B);
    end
    pop = rdy && (mcount != 0) && !redir;
    if (pop) begin
      chk("dec_pc", bus.dec_pc, exp_pc);
      chk("dec_instr", bus.dec_instr, f(exp_pc));
      exp_pc = exp_pc + 32'h4;
    end

    if (redir) begin
      mcount  = 0;
      exp_pc  = {rpc[31:2], 2'b00};
      nq      = exp_pc;
      exp_req = exp_pc & ~32'(B - 1);
    end else begin
      if (pop) mcount--;
      if (rv && !pend_stale) begin
        mcount += int'((pend_addr + 32'(B) - nq) >> 2);
        nq = pend_addr + 32'(B);
      end
    end
    if (rv) pend = 1'b0;
    else if (pend) begin
      lat--;
      if (redir) pend_stale = 1'b1;
    end
    if (gnt) begin
      pend       = 1'b1;
      pend_addr  = bus.mem_addr;
      pend_stale = redir;
      lat        = $urandom_range(lat_max, lat_min);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  gaps, k;
    bit  seen;
    bit  rd;
    logic [31:0] rpc;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.dec_ready = 1'b0;
    model_reset();
    gnt_mode = 1; rdy_mode = 1; lat_min = 0; lat_max = 0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_dec_valid", 32'(bus.dec_valid), 32'h0);
    chk("rst_fifo_count", 32'(bus.fifo_count), 32'h0);
    rst_n = 1'b1;

    // Streaming from RST_PC with immediate grant/response
    gaps = 0; seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (seen && !bus.dec_valid) gaps++;
      if (bus.dec_valid) seen = 1'b1;
      cycle(1'b0, 32'h0);
    end
    chk("stream_seen", 32'(seen), 32'h1);
    chk("stream_no_gaps", 32'(gaps), 32'h0);

    // Misaligned redirect: only the last two slots of the block enqueue
    rdy_mode = 0;
    cycle(1'b1, 32'h0000_1008);
    k = 0;
    while (bus.fifo_count == '0 && k < 20) begin cycle(1'b0, 32'h0); k++; end
    chk("misalign_count", 32'(bus.fifo_count), 32'h2);
    chk("misalign_head_pc", bus.dec_pc, 32'h0000_1008);
    chk("misalign_head_instr", bus.dec_instr, f(32'h0000_1008));

    // Credit: fill to DEPTH with the decoder stalled
    cycle(1'b1, 32'h0000_1100);
    k = 0;
    while (bus.fifo_count != 5'(DEPTH) && k < 100) begin cycle(1'b0, 32'h0); k++; end
    chk("full_count", 32'(bus.fifo_count), 32'(DEPTH));
    for (int c = 0; c < 6; c++) begin
      chk("no_req_full", 32'(bus.mem_req), 32'h0);
      cycle(1'b0, 32'h0);
    end
    rdy_mode = 1; cycle(1'b0, 32'h0); rdy_mode = 0;
    for (int c = 0; c < 6; c++) begin
      chk("no_req_free1", 32'(bus.mem_req), 32'h0);
      cycle(1'b0, 32'h0);
    end
    rdy_mode = 1; repeat (3) cycle(1'b0, 32'h0); rdy_mode = 0;
    k = 0;
    while (!bus.mem_req && k < 10) begin cycle(1'b0, 32'h0); k++; end
    chk("req_resume", 32'(bus.mem_req), 32'h1);

    // Redirect while waiting for the beat; the late beat must be dropped
    rdy_mode = 1; lat_min = 3; lat_max = 3;
    k = 0;
    while (!(pend && !pend_stale && lat == 3) && k < 20) begin cycle(1'b0, 32'h0); k++; end
    chk("wait_reached", 32'(pend && !pend_stale), 32'h1);
    cycle(1'b1, 32'h0000_2000);
    for (int c = 0; c < 5; c++) begin
      chk("drain_fifo_zero", 32'(bus.fifo_count), 32'h0);
      cycle(1'b0, 32'h0);
    end

    // Redirect in REQ without grant withdraws the request
    gnt_mode = 0;
    k = 0;
    while (!bus.mem_req && k < 30) begin cycle(1'b0, 32'h0); k++; end
    cycle(1'b1, 32'h0000_5000);
    chk("withdraw_req", 32'(bus.mem_req), 32'h0);

    // Redirect in REQ with same-cycle grant, second redirect in DRAIN wins
    k = 0;
    while (!bus.mem_req && k < 10) begin cycle(1'b0, 32'h0); k++; end
    gnt_mode = 1;
    cycle(1'b1, 32'h0000_3004);
    cycle(1'b1, 32'h0000_4000);
    k = 0;
    while (!bus.dec_valid && k < 30) begin cycle(1'b0, 32'h0); k++; end
    chk("drain_second_wins", bus.dec_pc, 32'h0000_4000);

    // Address wrap at the top of memory, random handshakes
    gnt_mode = 2; rdy_mode = 2; lat_min = 0; lat_max = 3;
    cycle(1'b1, 32'hFFFF_FFF0);
    for (int c = 0; c < 400; c++) cycle(1'b0, 32'h0);

    // Random traffic with occasional redirects
    for (int c = 0; c < 1500; c++) begin
      rd = ($urandom_range(0, 49) == 0) && !(pend && pend_stale && lat == 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FF00 | (rpc & 32'hFF);
      cycle(rd, rpc);
    end

    // Asynchronous reset with a request in flight
    gnt_mode = 1; rdy_mode = 1;
    k = 0;
    while (!pend && k < 30) begin cycle(1'b0, 32'h0); k++; end
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(bus.mem_req), 32'h0);
    chk("midrst_mem_addr", bus.mem_addr, 32'h0);
    chk("midrst_dec_valid", 32'(bus.dec_valid), 32'h0);
    chk("midrst_fifo_count", 32'(bus.fifo_count), 32'h0);
    model_reset();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    bus.redirect_valid = 1'b0; bus.dec_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    lat_min = 0; lat_max = 2;
    for (int c = 0; c < 40; c++) cycle(1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
